// File: rtl/noc_params_pkg.sv
// rtl/noc_params_pkg.sv - shared link parameters and flit type for the NoC buffer path
package noc_params_pkg;

  localparam int FLIT_SIZE   = 8;
  localparam int BUFFER_SIZE = 8;

  typedef logic [FLIT_SIZE-1:0] flit_t;

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - saturating free-slot counter with sticky overflow flag
module credit_counter #(
  parameter  int BUFFER_SIZE = 8,
  localparam int CREDIT_W    = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_i,
  input  logic                inc_i,
  output logic [CREDIT_W-1:0] count_o,
  output logic                nonzero_o,
  output logic                overflow_o
);

  localparam logic [CREDIT_W-1:0] MAX_CREDITS = CREDIT_W'(BUFFER_SIZE);
  localparam logic [CREDIT_W-1:0] ONE         = CREDIT_W'(1);

  logic [CREDIT_W-1:0] r_count;
  logic                r_overflow;

  // Track free slots; a returned credit at full count saturates and latches the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= MAX_CREDITS;
      r_overflow <= 1'b0;
    end else begin
      case ({dec_i, inc_i})
        2'b10: r_count <= r_count - ONE;
        2'b01: begin
          if (r_count == MAX_CREDITS) begin
            r_overflow <= 1'b1;
          end else begin
            r_count <= r_count + ONE;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

  assign count_o    = r_count;
  assign nonzero_o  = (r_count != '0);
  assign overflow_o = r_overflow;

endmodule

// File: rtl/credit_flit_sender.sv
// rtl/credit_flit_sender.sv - credit-based flit sender feeding a downstream circular buffer
module credit_flit_sender
  import noc_params_pkg::*;
#(
  parameter  int BUFFER_SIZE = noc_params_pkg::BUFFER_SIZE,
  parameter  int FLIT_SIZE   = noc_params_pkg::FLIT_SIZE,
  localparam int CREDIT_W    = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 ready_o,
  input  logic                 credit_i,
  output logic                 write_o,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic [CREDIT_W-1:0]  credits_o,
  output logic                 error_o
);

  logic                 w_nonzero;
  logic                 w_transfer;
  logic                 r_write;
  logic [FLIT_SIZE-1:0] r_data;

  // Ready depends only on the credit count so the source cannot create a loop through valid_i.
  assign ready_o    = w_nonzero;
  assign w_transfer = valid_i && w_nonzero;

  credit_counter #(
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_credit_counter (
    .clk        (clk),
    .rst        (rst),
    .dec_i      (w_transfer),
    .inc_i      (credit_i),
    .count_o    (credits_o),
    .nonzero_o  (w_nonzero),
    .overflow_o (error_o)
  );

  // Register each accepted flit as a single-cycle write; data holds between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_data  <= '0;
    end else begin
      r_write <= w_transfer;
      if (w_transfer) begin
        r_data <= data_i;
      end
    end
  end

  assign write_o = r_write;
  assign data_o  = r_data;

endmodule
